// File: rtl/dmem_responder.sv
// Multi-cycle 16-bit data-memory responder behind the memory-stage request/stall interface.
// One access is in flight at a time; Stall is combinational and Done is a registered pulse.
module dmem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic                 err_next;
  logic                 commit;
  logic                 req;
  logic                 illegal;
  logic [ADDR_BITS-1:0] idx;
  logic                 unused_addr_hi;
  logic [15:0]          mem [DEPTH];

  assign req            = Rd | Wr;
  assign illegal        = (Rd & Wr) | Addr[0];
  assign idx            = Addr[ADDR_BITS:1];
  assign unused_addr_hi = ^Addr[15:ADDR_BITS+1];
  assign Stall          = rst & req & ~Done;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = Err;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            err_next = 1'b1;
          end else begin
            cnt_next = CNT_LOAD;
            if (LATENCY == 1) begin
              commit     = 1'b1;
              state_next = DONE;
            end else begin
              state_next = BUSY;
            end
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        // A dropped request aborts even on the final count: nothing is committed.
        if (!req) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (cnt == 4'd1) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      Done    <= 1'b0;
      DataOut <= '0;
      Err     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      Done  <= (state_next == DONE);
      Err   <= err_next;
      if (commit) begin
        DataOut <= Wr ? '0 : mem[idx];
      end
    end
  end

  // Storage has no reset; a reset edge suppresses any commit so memory is untouched.
  always_ff @(posedge clk) begin
    if (rst && commit && Wr) begin
      mem[idx] <= DataIn;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=4 and a LATENCY=1 instance driven independently.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  rd_v, wr_v, done_v, stall_v, err_v;
  logic [15:0] addr_v [2];
  logic [15:0] din_v  [2];
  logic [15:0] dout_v [2];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  dmem_responder #(.LATENCY(4), .ADDR_BITS(10)) dut4 (
    .clk(clk), .rst(rst), .Rd(rd_v[0]), .Wr(wr_v[0]), .Addr(addr_v[0]), .DataIn(din_v[0]),
    .DataOut(dout_v[0]), .Done(done_v[0]), .Stall(stall_v[0]), .Err(err_v[0])
  );

  dmem_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (
    .clk(clk), .rst(rst), .Rd(rd_v[1]), .Wr(wr_v[1]), .Addr(addr_v[1]), .DataIn(din_v[1]),
    .DataOut(dout_v[1]), .Done(done_v[1]), .Stall(stall_v[1]), .Err(err_v[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // Scoreboard monitor: every Done must match a pending expected DataOut.
  always @(negedge clk) begin
    if (done_v[0]) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done_lat4: got Done=1, required no pending access (t=%0t)", $time);
      end else begin
        chk("dout_lat4", dout_v[0], q0.pop_front());
      end
    end
    if (done_v[1]) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done_lat1: got Done=1, required no pending access (t=%0t)", $time);
      end else begin
        chk("dout_lat1", dout_v[1], q1.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b0;
    rd_v      = 2'b01;
    wr_v      = 2'b00;
    addr_v[0] = 16'h0010;
    cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_done",  16'(done_v[d]),  16'h0000);
      chk("rst_dout",  dout_v[d],       16'h0000);
      chk("rst_err",   16'(err_v[d]),   16'h0000);
      chk("rst_stall", 16'(stall_v[d]), 16'h0000);
    end
    cyc();
    rst  = 1'b1;
    rd_v = 2'b00;
  endtask

  // Issue one legal access at cycle T and check Stall/Done cycle by cycle through T+lat.
  task automatic access(input int d, input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [15:0] exp);
    int lat;
    lat       = (d == 0) ? 4 : 1;
    rd_v[d]   = rd;
    wr_v[d]   = wr;
    addr_v[d] = addr;
    din_v[d]  = data;
    if (d == 0) q0.push_back(exp);
    else        q1.push_back(exp);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk("stall_busy", 16'(stall_v[d]), 16'h0001);
      chk("done_early", 16'(done_v[d]),  16'h0000);
      cyc();
    end
    @(negedge clk);
    chk("stall_at_done", 16'(stall_v[d]), 16'h0000);
    chk("done_pulse",    16'(done_v[d]),  16'h0001);
    cyc();
    rd_v[d] = 1'b0;
    wr_v[d] = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    rd_v      = '0;
    wr_v      = '0;
    addr_v[0] = '0;
    addr_v[1] = '0;
    din_v[0]  = '0;
    din_v[1]  = '0;
    do_reset();

    // Write then back-to-back read, LATENCY=4
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // Word index wraps modulo 1024 words
    access(0, 1'b0, 1'b1, 16'h0004, 16'hA5A5, 16'h0000);
    access(0, 1'b1, 1'b0, 16'h0804, 16'h0000, 16'hA5A5);

    // Rd held across Done: Stall returns at cycle 5, next Done at cycle 9
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    chk("err_clean_lat4", 16'(err_v[0]), 16'h0000);

    // LATENCY=1 write/read
    access(1, 1'b0, 1'b1, 16'h0002, 16'h1234, 16'h0000);
    access(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1234);
    chk("err_clean_lat1", 16'(err_v[1]), 16'h0000);

    // Rd & Wr together in IDLE
    rd_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 16'h0010;
    @(negedge clk);
    chk("rdwr_stall", 16'(stall_v[0]), 16'h0001);
    cyc();
    @(negedge clk);
    chk("rdwr_stall2", 16'(stall_v[0]), 16'h0001);
    chk("rdwr_err",    16'(err_v[0]),   16'h0001);
    cyc();
    rd_v[0] = 1'b0; wr_v[0] = 1'b0;
    idle(4);
    @(negedge clk);
    chk("rdwr_err_sticky", 16'(err_v[0]),   16'h0001);
    chk("rdwr_idle_stall", 16'(stall_v[0]), 16'h0000);
    cyc();

    // Misaligned address
    do_reset();
    rd_v[0] = 1'b1; addr_v[0] = 16'h0003;
    @(negedge clk);
    chk("misalign_stall", 16'(stall_v[0]), 16'h0001);
    cyc();
    @(negedge clk);
    chk("misalign_err", 16'(err_v[0]), 16'h0001);
    cyc();
    rd_v[0] = 1'b0;
    idle(4);

    // Wr dropped in cycle 2 of a write
    do_reset();
    access(0, 1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000);
    wr_v[0] = 1'b1; addr_v[0] = 16'h0020; din_v[0] = 16'h2222;
    @(negedge clk);
    chk("drop_stall0", 16'(stall_v[0]), 16'h0001);
    cyc();
    @(negedge clk);
    chk("drop_stall1", 16'(stall_v[0]), 16'h0001);
    cyc();
    wr_v[0] = 1'b0;
    @(negedge clk);
    chk("drop_stall2", 16'(stall_v[0]), 16'h0000);
    cyc();
    @(negedge clk);
    chk("drop_err",  16'(err_v[0]),  16'h0001);
    chk("drop_done", 16'(done_v[0]), 16'h0000);
    cyc();
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111);

    // Reset in cycle 2 of a write over stored data
    access(0, 1'b0, 1'b1, 16'h0030, 16'h0F0F, 16'h0000);
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0F0F);
    wr_v[0] = 1'b1; addr_v[0] = 16'h0030; din_v[0] = 16'h5555;
    @(negedge clk);
    chk("rstmid_stall0", 16'(stall_v[0]), 16'h0001);
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_stall_in_rst", 16'(stall_v[0]), 16'h0000);
    cyc();
    rst = 1'b1; wr_v[0] = 1'b0;
    @(negedge clk);
    chk("rstmid_done", 16'(done_v[0]), 16'h0000);
    chk("rstmid_err",  16'(err_v[0]),  16'h0000);
    chk("rstmid_dout", dout_v[0],      16'h0000);
    cyc();
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0F0F);

    idle(3);
    chk("q_lat4_drained", 16'(q0.size()), 16'h0000);
    chk("q_lat1_drained", 16'(q1.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that sits on the far side of the processor memory stage's request/stall interface. It accepts one read or write request at a time and holds `Stall` high while the access is in flight. When the access completes, it pulses `Done` with read data. The pipeline uses `Stall` directly to freeze its pipeline registers, so the stall path is combinational from the request inputs. The block replaces the single-cycle data memory and gives the stall logic a real multi-cycle responder.

## Interface
Parameters:
- `LATENCY`, default 4: cycles from first request cycle to `Done`. Legal range 1..15.
- `ADDR_BITS`, default 10: log2 of word depth. Storage is 2^ADDR_BITS 16-bit words.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `Rd`  in  1  read request.
- `Wr`  in  1  write request.
- `Addr`  in  16  byte address; `Addr[0]` must be 0.
- `DataIn`  in  16  write data.
- `DataOut`  out  16  read data; valid only while `Done` = 1.
- `Done`  out  1  registered, one-cycle completion pulse.
- `Stall`  out  1  combinational; requester must hold `Rd`, `Wr`, `Addr` and `DataIn` stable while this is high.
- `Err`  out  1  sticky protocol/alignment error flag.

## Operation
- A request is present when `Rd` | `Wr` is 1. The word index is `Addr[ADDR_BITS:1]`; higher address bits are ignored, so addresses wrap modulo the depth.
- FSM states are IDLE, BUSY and DONE.
  - **IDLE:** On a legal request, load `cnt` with `LATENCY`-1.
    - If `LATENCY` = 1, go straight to DONE and commit the access at this edge.
    - Otherwise go to BUSY.
  - **BUSY:** Decrement `cnt` each cycle.
    - When `cnt` = 1, commit the access and go to DONE.
    - If the request drops while in BUSY, set `Err`, go to IDLE and commit nothing.
  - **DONE:** `Done` = 1 and `DataOut` holds the read word. Next state is always IDLE, even if a request is still present.
- Committing an access:
  - For a write, the memory array takes `DataIn` at the index.
  - For a read, the array word is latched into the `DataOut` register.
  - For a write, `DataOut` is set to 0.
- `Stall` = (`Rd` | `Wr`) & ~`Done`. `Stall` is 0 while `rst` is asserted.
- Illegal requests:
  - An illegal request is `Rd` & `Wr`, or `Addr[0]` = 1.
  - In IDLE, an illegal request sets `Err`. The FSM stays in IDLE, no access happens, and `Stall` still follows the formula above.
  - The requester must clear an illegal request; this block does not recover from it on its own.
- `Err`, once set, stays 1 until reset.
- Memory contents are not initialised and are not cleared by reset. Reads of words that were never written return undefined data.

## Timing
- Reset values: state IDLE, `cnt` 0, `Done` 0, `DataOut` 16'h0000, `Err` 0, `Stall` 0.
- Latency: the request first appears in cycle T.
  - `Stall` is 1 for cycles T..T+`LATENCY`-1.
  - In cycle T+`LATENCY`, `Done` = 1, `Stall` = 0 and `DataOut` is valid.
  - The requester's pipeline advances on the edge that ends cycle T+`LATENCY`.
- Back-to-back requests: a new request in cycle T+`LATENCY`+1 starts a fresh access. Sustained throughput is one access per `LATENCY`+1 cycles.
- A write becomes visible to a read whose request starts in the cycle after its `Done`.
- Reset taken in BUSY: the access is aborted and memory is not modified. Outputs return to their reset values on the following cycle.
- Reset taken in DONE: `Done` drops on the next cycle. The write was already committed.

## Test plan
- **Write then read, `LATENCY`=4:**
  - Write 16'hBEEF to 16'h0010 at T=0. `Stall` = 1 for cycles 0..3; `Done` = 1 at cycle 4 and at no other cycle.
  - Then read 16'h0010 starting at T=5. `Stall` = 1 for cycles 5..8; at cycle 9, `Done` = 1 and `DataOut` = 16'hBEEF.
- **`LATENCY`=1:**
  - Write 16'h1234 to 16'h0002, then read it back.
  - Each access shows `Stall` = 1 for exactly one cycle, then `Done` one cycle later. The read returns 16'h1234.
- **Wrap-around, `ADDR_BITS`=10:**
  - Write 16'hA5A5 to 16'h0004, then read 16'h0804.
  - The read returns 16'hA5A5.
- **Protocol errors:**
  - `Rd`=`Wr`=1 in IDLE sets `Err` = 1; `Done` never pulses.
  - `Addr`=16'h0003 sets `Err`.
  - Dropping `Wr` in cycle 2 of a `LATENCY`=4 write sets `Err`. A following read of that address returns the previous contents.
- **Reset mid-access:**
  - Assert `rst`=0 in cycle 2 of a write of 16'h5555 over stored 16'h0F0F.
  - After reset: `Done`=0, `Err`=0 and `DataOut`=0. A following read returns 16'h0F0F.
- **Held request after `Done`:**
  - Keep `Rd` asserted through and after cycle 4.
  - `Stall` returns to 1 at cycle 5, and the next `Done` appears at cycle 9.
